// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: zero-wait burst writes/reads into a 128-bit word array, two-cycle ERROR, registered side read port.
// Optional macro AHB_SRAM_WR_CNT_EN adds a saturating completed-write-beat counter (wr_count / wr_count_clr).
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | no data phase pending
// S_DATA | legal transfer latched, data phase in progress
// S_ERR1 | first ERROR cycle (HREADY=0, HRESP=1)
// S_ERR2 | second ERROR cycle (HREADY=1, HRESP=1)
module ahb_sram_slave #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1100
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     HWRITE,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HTRANS,
  input  logic [31:0]              HADDR,
  input  logic [127:0]             HWDATA,
  output logic [127:0]             HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
`ifdef AHB_SRAM_WR_CNT_EN
  input  logic                     wr_count_clr,
  output logic [15:0]              wr_count,
`endif
  output logic [127:0]             rd_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               write_q, write_d;
  logic               burst_open_q, burst_open_d;
  logic [31:0]        prev_addr_q, prev_addr_d;
  logic [127:0]       mem_q [DEPTH];
  logic [127:0]       mem_d [DEPTH];
  logic [127:0]       rd_data_q, rd_data_d;

  logic        hready;
  logic        accept;
  logic        addr_ok;
  logic        seq_ok;
  logic        legal;
  logic        wr_fire;
  logic [31:0] offset;
  logic [31:0] word_off;

  assign hready   = (state_q != S_ERR1);
  assign accept   = hready && HTRANS[1];
  assign offset   = HADDR - BASE_ADDR;
  assign word_off = offset >> 4;
  assign addr_ok  = (HADDR[3:0] == 4'h0) && (HADDR >= BASE_ADDR) && (word_off < 32'(DEPTH));
  // SEQ must continue an open burst at exactly the next 16-byte word.
  assign seq_ok   = burst_open_q && (HADDR == prev_addr_q + 32'd16);
  assign legal    = addr_ok && ((HTRANS == HT_NONSEQ) || seq_ok);
  assign wr_fire  = (state_q == S_DATA) && write_q;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    write_d      = write_q;
    burst_open_d = burst_open_q;
    prev_addr_d  = prev_addr_q;
    case (state_q)
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept) begin
          if (legal) begin
            state_d      = S_DATA;
            index_d      = word_off[IDX_W-1:0];
            write_d      = HWRITE;
            burst_open_d = (HTRANS == HT_NONSEQ) ? (HBURST != 3'b000) : 1'b1;
            prev_addr_d  = HADDR;
          end else begin
            state_d      = S_ERR1;
            write_d      = 1'b0;
            burst_open_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) mem_d[index_q] = HWDATA;
  end

  // Side port samples mem_q, so a same-cycle write is seen only on the next read.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = (32'(rd_addr) < 32'(DEPTH)) ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      write_q      <= 1'b0;
      burst_open_q <= 1'b0;
      prev_addr_q  <= '0;
      rd_data_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      write_q      <= write_d;
      burst_open_q <= burst_open_d;
      prev_addr_q  <= prev_addr_d;
      rd_data_q    <= rd_data_d;
      mem_q        <= mem_d;
    end
  end

  assign HREADY  = hready;
  assign HRESP   = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA  = ((state_q == S_DATA) && !write_q) ? mem_q[index_q] : '0;
  assign rd_data = rd_data_q;

`ifdef AHB_SRAM_WR_CNT_EN
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_count_clr)                         wr_count_d = '0;
    else if (wr_fire && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed self-checking bench for ahb_sram_slave: bursts, errors, burst gaps, range, readback, BUSY.
module tb_ahb_sram_slave;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         HWRITE;
  logic [2:0]   HBURST;
  logic [1:0]   HTRANS;
  logic [31:0]  HADDR;
  logic [127:0] HWDATA;
  logic [127:0] HRDATA;
  logic         HREADY;
  logic         HRESP;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
`ifdef AHB_SRAM_WR_CNT_EN
  logic         wr_count_clr;
  logic [15:0]  wr_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [127:0] D11 = {16{8'h11}}, DFF = {16{8'hFF}}, DA1 = {16{8'hA1}};
  localparam logic [127:0] D55 = {16{8'h55}}, D22 = {16{8'h22}}, D33 = {16{8'h33}};
  localparam logic [127:0] D44 = {16{8'h44}}, D66 = {16{8'h66}}, D77 = {16{8'h77}};
  localparam logic [127:0] D88 = {16{8'h88}}, D99 = {16{8'h99}};

  ahb_sram_slave dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .HWRITE  (HWRITE),
    .HBURST  (HBURST),
    .HTRANS  (HTRANS),
    .HADDR   (HADDR),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
`ifdef AHB_SRAM_WR_CNT_EN
    .wr_count_clr (wr_count_clr),
    .wr_count     (wr_count),
`endif
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic rsp);
    chk({tag, "_hready"}, {127'd0, HREADY}, {127'd0, rdy});
    chk({tag, "_hresp"},  {127'd0, HRESP},  {127'd0, rsp});
  endtask

  task automatic side_rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    rd_en   = 1'b1;
    rd_addr = idx;
    step();
    rd_en   = 1'b0;
    chk(tag, rd_data, exp);
  endtask

  task automatic addr_ph(input logic [1:0] tr, input logic wr, input logic [2:0] bu, input logic [31:0] a);
    HTRANS = tr;
    HWRITE = wr;
    HBURST = bu;
    HADDR  = a;
  endtask

  initial begin
    n_rst = 1'b0;
    HWRITE = 1'b0; HBURST = 3'd0; HTRANS = IDLE; HADDR = '0; HWDATA = '0;
    rd_en = 1'b0; rd_addr = '0;
`ifdef AHB_SRAM_WR_CNT_EN
    wr_count_clr = 1'b0;
`endif
    #23 n_rst = 1'b1;
    step();

    // 1. reset state
    chk_resp("reset", 1'b1, 1'b0);
    chk("reset_hrdata", HRDATA, '0);
    for (int i = 0; i < 16; i++) side_rd($sformatf("reset_mem%0d", i), 4'(i), '0);

    // 2. INCR burst of three beats
    addr_ph(NONSEQ, 1'b1, 3'd1, 32'h1100);
    step();
    chk_resp("burst_b0", 1'b1, 1'b0);
    HWDATA = D11; addr_ph(SEQ, 1'b1, 3'd1, 32'h1110);
    step();
    chk_resp("burst_b1", 1'b1, 1'b0);
    HWDATA = DFF; addr_ph(SEQ, 1'b1, 3'd1, 32'h1120);
    step();
    chk_resp("burst_b2", 1'b1, 1'b0);
    HWDATA = DA1; addr_ph(IDLE, 1'b0, 3'd0, 32'h0);
    step();
    chk_resp("burst_end", 1'b1, 1'b0);
    side_rd("burst_idx0", 4'd0, D11);
    side_rd("burst_idx1", 4'd1, DFF);
    side_rd("burst_idx2", 4'd2, DA1);
`ifdef AHB_SRAM_WR_CNT_EN
    chk("wr_count_3", {112'd0, wr_count}, 128'd3);
`endif

    // 3. misaligned write
    addr_ph(NONSEQ, 1'b1, 3'd0, 32'h1111);
    step();
    chk_resp("misal_err1", 1'b0, 1'b1);
    HWDATA = D55; addr_ph(IDLE, 1'b0, 3'd0, 32'h0);
    step();
    chk_resp("misal_err2", 1'b1, 1'b1);
    step();
    chk_resp("misal_after", 1'b1, 1'b0);
    side_rd("misal_idx1", 4'd1, DFF);

    // 4. burst with address gap
    addr_ph(NONSEQ, 1'b1, 3'd1, 32'h1100);
    step();
    chk_resp("gap_b0", 1'b1, 1'b0);
    HWDATA = D22; addr_ph(SEQ, 1'b1, 3'd1, 32'h1130);
    step();
    chk_resp("gap_err1", 1'b0, 1'b1);
    HWDATA = D33; addr_ph(IDLE, 1'b0, 3'd0, 32'h0);
    step();
    chk_resp("gap_err2", 1'b1, 1'b1);
    step();
    side_rd("gap_idx3", 4'd3, '0);
    side_rd("gap_idx0", 4'd0, D22);
    addr_ph(NONSEQ, 1'b1, 3'd1, 32'h1130);
    step();
    chk_resp("gap_retry", 1'b1, 1'b0);
    HWDATA = D44; addr_ph(IDLE, 1'b0, 3'd0, 32'h0);
    step();
    side_rd("gap_retry_idx3", 4'd3, D44);

    // 5. out of range (index 16)
    addr_ph(NONSEQ, 1'b1, 3'd0, 32'h1200);
    step();
    chk_resp("oor_err1", 1'b0, 1'b1);
    HWDATA = D55; addr_ph(IDLE, 1'b0, 3'd0, 32'h0);
    step();
    chk_resp("oor_err2", 1'b1, 1'b1);
    step();
    side_rd("oor_idx0", 4'd0, D22);
    side_rd("oor_idx15", 4'd15, '0);

    // 6a. write then immediate read of 0x1140; side read during the write sees old data
    addr_ph(NONSEQ, 1'b1, 3'd0, 32'h1140);
    step();
    HWDATA = D66; addr_ph(NONSEQ, 1'b0, 3'd0, 32'h1140);
    rd_en = 1'b1; rd_addr = 4'd4;
    step();
    rd_en = 1'b0;
    chk("rbw_side_old", rd_data, '0);
    chk("rd_hrdata", HRDATA, D66);
    chk_resp("rd_resp", 1'b1, 1'b0);
    addr_ph(IDLE, 1'b0, 3'd0, 32'h0);
    step();
    chk("rd_hrdata_idle", HRDATA, '0);
    chk("side_hold", rd_data, '0);
    side_rd("rd_idx4", 4'd4, D66);

    // 6b. BUSY mid-burst
    addr_ph(NONSEQ, 1'b1, 3'd1, 32'h1150);
    step();
    HWDATA = D77; addr_ph(BUSY, 1'b1, 3'd1, 32'h1160);
    step();
    chk_resp("busy_resp", 1'b1, 1'b0);
    HWDATA = D99; addr_ph(SEQ, 1'b1, 3'd1, 32'h1160);
    step();
    chk_resp("busy_seq", 1'b1, 1'b0);
    HWDATA = D88; addr_ph(IDLE, 1'b0, 3'd0, 32'h0);
    step();
    side_rd("busy_idx5", 4'd5, D77);
    side_rd("busy_idx6", 4'd6, D88);
    side_rd("busy_idx7", 4'd7, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
